// File: rtl/clb_pkg.sv
// clb_pkg: load-controller state encoding, clog2 helper and default derived widths for clb_multi_ble
package clb_pkg;
    typedef enum logic [1:0] {UNCFG, SHIFT, CONFIGURED, ERROR} cfg_state_t;
    function automatic int clog2(input int v);
        int r = 0;
        for (int b = 0; b < 31; b++) if ((1 << b) < v) r = b + 1;
        return r;
    endfunction
    localparam int DEF_K = 4;
    localparam int DEF_N = 4;
    localparam int DEF_I = 10;
    localparam int SEL_W = clog2(DEF_I + DEF_N + 1);
    localparam int BLE_BITS = (1 << DEF_K) + 1 + DEF_K * SEL_W;
    localparam int CFG_BITS = DEF_N * BLE_BITS;
endpackage

// File: rtl/ble_k.sv
// ble_k: K-input LUT with async-reset FF and comb/registered output select; ports clk, rst, tt (truth table), is_comb, x (LUT inputs), hold (freeze FF), y (raw output)
module ble_k #(
    parameter int K = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [(1<<K)-1:0] tt,
    input  logic             is_comb,
    input  logic [K-1:0]     x,
    input  logic             hold,
    output logic             y
);
    logic lut, q;
    assign lut = tt[x];
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= 1'b0;
        else if (!hold) q <= lut;
    assign y = is_comb ? lut : q;
endmodule

// File: rtl/clb_multi_ble.sv
// clb_multi_ble: N K-input BLEs behind a full crossbar with feedback, scan-loaded config; ports clk, rst, scan_en, scan_in, scan_out, clb_in[I], clb_out[N], cfg_done
module clb_multi_ble
    import clb_pkg::*;
#(
    parameter int K        = 4,
    parameter int N        = 4,
    parameter int I        = 10,
    parameter int SEL_W    = clog2(I + N + 1),
    parameter int BLE_BITS = (1 << K) + 1 + K * SEL_W,
    parameter int CFG_BITS = N * BLE_BITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         scan_en,
    input  logic         scan_in,
    output logic         scan_out,
    input  logic [I-1:0] clb_in,
    output logic [N-1:0] clb_out,
    output logic         cfg_done
);
    localparam int CNT_W = clog2(CFG_BITS + 2);
    localparam int SRC_W = 1 << SEL_W;
    logic [CFG_BITS-1:0] cfg;
    logic [N-1:0]        raw;
    logic [SRC_W-1:0]    src;
    logic [CNT_W-1:0]    cnt, cnt_n;
    cfg_state_t          state, state_n;
    // padding with zeros makes every select value >= I+N read a constant 0
    assign src = {{(SRC_W - I - N){1'b0}}, raw, clb_in};
    always_ff @(posedge clk or posedge rst)
        if (rst) cfg <= '0;
        else if (scan_en) cfg <= {scan_in, cfg[CFG_BITS-1:1]};
    for (genvar b = 0; b < N; b++) begin : g_ble
        localparam int BASE = b * BLE_BITS;
        logic [K-1:0] x;
        for (genvar k = 0; k < K; k++) begin : g_in
            assign x[k] = src[cfg[BASE + (1 << K) + 1 + k * SEL_W +: SEL_W]];
        end
        ble_k #(.K(K)) u_ble (
            .clk     (clk),
            .rst     (rst),
            .tt      (cfg[BASE +: (1 << K)]),
            .is_comb (cfg[BASE + (1 << K)]),
            .x       (x),
            .hold    (scan_en),
            .y       (raw[b])
        );
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= UNCFG;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == SHIFT) begin
            if (scan_en) cnt_n = (cnt == CNT_W'(CFG_BITS + 1)) ? cnt : cnt + CNT_W'(1);
            else state_n = (cnt == CNT_W'(CFG_BITS)) ? CONFIGURED : ERROR;
        end else if (scan_en) begin
            state_n = SHIFT;
            cnt_n   = CNT_W'(1);
        end
    end
    assign cfg_done = state == CONFIGURED;
    assign clb_out  = cfg_done ? raw : '0;
    assign scan_out = cfg[0];
endmodule

// File: tb/tb_clb_multi_ble.sv
// tb_clb_multi_ble: directed self-checking bench for clb_multi_ble at default parameters
module tb_clb_multi_ble;
    logic         clk = 1'b0;
    logic         rst, scan_en, scan_in, scan_out, cfg_done;
    logic [9:0]   clb_in;
    logic [3:0]   clb_out;
    logic [131:0] cur, v1, v2, v3, v4, v5;
    int           n_tests = 0;
    int           n_fail = 0;

    clb_multi_ble dut (
        .clk      (clk),
        .rst      (rst),
        .scan_en  (scan_en),
        .scan_in  (scan_in),
        .scan_out (scan_out),
        .clb_in   (clb_in),
        .clb_out  (clb_out),
        .cfg_done (cfg_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] ble(input logic [15:0] tt, input logic c,
                                        input logic [3:0] s0, s1, s2, s3);
        return {s3, s2, s1, s0, c, tt};
    endfunction

    task automatic shift(input logic [131:0] v, input int n);
        scan_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            scan_in = (i < 132) ? v[i] : 1'b0;
            @(posedge clk); #1;
            cur = {scan_in, cur[131:1]};
            check("scan_out", 32'(scan_out), 32'(cur[0]));
        end
    endtask

    task automatic finish_load();
        scan_en = 1'b0;
        scan_in = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; scan_en = 1'b0; scan_in = 1'b0; clb_in = '0; cur = '0;
        #12;
        check("rst_done", 32'(cfg_done), 0);
        check("rst_out", 32'(clb_out), 0);
        check("rst_scan", 32'(scan_out), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("uncfg_idle", 32'(cfg_done), 0);

        v1 = {99'b0, ble(16'h8000, 1'b1, 4'd0, 4'd1, 4'd2, 4'd3)};
        shift(v1, 132);
        check("and_shifting", 32'(cfg_done), 0);
        finish_load();
        check("and_done", 32'(cfg_done), 1);
        clb_in = 10'h00F; #1;
        check("and_comb_hi", 32'(clb_out), 1);
        clb_in = 10'h007; #1;
        check("and_comb_lo", 32'(clb_out), 0);

        v2 = {99'b0, ble(16'h8000, 1'b0, 4'd0, 4'd1, 4'd2, 4'd3)};
        clb_in = '0;
        scan_en = 1'b1; scan_in = v2[0]; #1;
        check("done_lag", 32'(cfg_done), 1);
        shift(v2, 132);
        check("done_drop", 32'(cfg_done), 0);
        finish_load();
        check("reg_done", 32'(cfg_done), 1);
        check("reg_init", 32'(clb_out), 0);
        clb_in = 10'h00F; #1;
        check("reg_nolat", 32'(clb_out), 0);
        @(posedge clk); #1;
        check("reg_rise", 32'(clb_out), 1);
        clb_in = 10'h007;
        @(posedge clk); #1;
        check("reg_fall", 32'(clb_out), 0);

        v3 = {33'b0, ble(16'h0001, 1'b1, 4'd15, 4'd15, 4'd15, 4'd15), 66'b0};
        shift(v3, 131);
        finish_load();
        check("short_done", 32'(cfg_done), 0);
        check("short_out", 32'(clb_out), 0);
        shift(v3, 133);
        finish_load();
        check("over_done", 32'(cfg_done), 0);
        check("over_out", 32'(clb_out), 0);
        shift(v3, 132);
        finish_load();
        check("exact_done", 32'(cfg_done), 1);
        check("const_one", 32'(clb_out), 32'h4);

        #2 rst = 1'b1; cur = '0;
        #2 rst = 1'b0;
        v4 = {33'b0, ble(16'h0001, 1'b1, 4'd15, 4'd15, 4'd15, 4'd15),
              ble(16'h5555, 1'b0, 4'd11, 4'd15, 4'd15, 4'd15), 33'b0};
        shift(v4, 132);
        finish_load();
        check("fb_first", 32'(clb_out), 32'h6);
        for (int i = 0; i < 4; i++) begin
            clb_in = (i == 0) ? 10'h000 : (i == 1) ? 10'h3FF : (i == 2) ? 10'h155 : 10'h2AA;
            @(posedge clk); #1;
            check("fb_toggle", 32'(clb_out), (i % 2 == 0) ? 32'h4 : 32'h6);
        end

        v5 = '1;
        shift(v5, 132);
        finish_load();
        check("ones_out", 32'(clb_out), 32'hF);
        shift(v5, 70);
        check("mid_scan", 32'(scan_out), 1);
        #2 rst = 1'b1; #1;
        check("arst_scan", 32'(scan_out), 0);
        check("arst_out", 32'(clb_out), 0);
        check("arst_done", 32'(cfg_done), 0);
        cur = '0;
        scan_en = 1'b0; scan_in = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("arst_uncfg", 32'(cfg_done), 0);
        shift('0, 132);
        check("drain_done", 32'(cfg_done), 0);
        scan_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
